// File: rtl/accum_buf_pkg.sv
// Shared types and arithmetic helpers for the multi-channel output
// accumulation buffer. Optional saturation is selected by ACCUM_BUF_SAT_EN.
package accum_buf_pkg;

  // Working width for the lane helpers; lane and accumulator widths must stay below it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } accum_buf_state_e;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             sat;
  } sat_res_t;

  // Extend the low w bits of din to MAX_W bits, by sign or by zeros.
  function automatic logic [MAX_W-1:0] ext_lane(input logic [MAX_W-1:0] din,
                                                input int w,
                                                input logic is_signed);
    logic [MAX_W-1:0] low_mask;
    logic [MAX_W-1:0] sign_mask;
    logic             sign;
    low_mask  = ~({MAX_W{1'b1}} << w);
    sign_mask = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    sign      = is_signed & (|(din & sign_mask));
    return (din & low_mask) | (sign ? ~low_mask : '0);
  endfunction

  // Add an already-extended addend to an acc_w-bit accumulator and clamp
  // the result to the acc_w-bit signed or unsigned range.
  function automatic sat_res_t sat_add(input logic [MAX_W-1:0] acc,
                                       input logic [MAX_W-1:0] addend,
                                       input int acc_w,
                                       input logic is_signed);
    sat_res_t         res;
    logic [MAX_W-1:0] low_mask;
    logic [MAX_W-1:0] half;
    logic [MAX_W-1:0] s;
    logic [MAX_W-1:0] upper;
    low_mask = ~({MAX_W{1'b1}} << acc_w);
    half     = low_mask >> 1;
    s        = ext_lane(acc, acc_w, is_signed) + addend;
    upper    = s & ~half;
    res.sat  = 1'b0;
    res.sum  = s & low_mask;
    if (is_signed) begin
      // Representable only if every bit from acc_w-1 upward equals the sign.
      if (upper != '0 && upper != ~half) begin
        res.sat = 1'b1;
        res.sum = s[MAX_W-1] ? (~half & low_mask) : half;
      end
    end else if ((s & ~low_mask) != '0) begin
      res.sat = 1'b1;
      res.sum = low_mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One accumulation lane: extend the incoming lane value and add it into
// the lane register. With ACCUM_BUF_SAT_EN the add saturates and a sticky
// flag records any clamp; otherwise the add wraps.
module accum_lane
  import accum_buf_pkg::*;
#(
  parameter int IN_W  = 20,
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             add_en,
  input  logic             is_signed,
  input  logic [IN_W-1:0]  lane_data,
  output logic [ACC_W-1:0] acc
`ifdef ACCUM_BUF_SAT_EN
  ,output logic            sat_flag
`endif
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic [MAX_W-1:0] addend;

`ifdef ACCUM_BUF_SAT_EN
  logic     sat_reg;
  logic     sat_next;
  sat_res_t res;
`endif

  // Next accumulator value: clear wins, otherwise add the extended lane.
  always_comb begin
    addend   = ext_lane(MAX_W'(lane_data), IN_W, is_signed);
    acc_next = acc_reg;
`ifdef ACCUM_BUF_SAT_EN
    sat_next = sat_reg;
    res      = sat_add(MAX_W'(acc_reg), addend, ACC_W, is_signed);
    if (clear) begin
      acc_next = '0;
      sat_next = 1'b0;
    end else if (add_en) begin
      acc_next = ACC_W'(res.sum);
      sat_next = sat_reg | res.sat;
    end
`else
    if (clear) begin
      acc_next = '0;
    end else if (add_en) begin
      acc_next = acc_reg + ACC_W'(addend);
    end
`endif
  end

  // Lane state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_reg <= '0;
`ifdef ACCUM_BUF_SAT_EN
      sat_reg <= 1'b0;
`endif
    end else begin
      acc_reg <= acc_next;
`ifdef ACCUM_BUF_SAT_EN
      sat_reg <= sat_next;
`endif
    end
  end

  assign acc = acc_reg;
`ifdef ACCUM_BUF_SAT_EN
  assign sat_flag = sat_reg;
`endif

endmodule

// File: rtl/accum_buffer_array.sv
// Multi-channel output accumulation buffer. Accumulates NUM_CH lanes over a
// programmable number of beats, then drains one channel per handshake.
// Optional per-lane saturation and sat_flag_o port: define ACCUM_BUF_SAT_EN.
module accum_buffer_array
  import accum_buf_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  IN_W    = 20,
  parameter int  ACC_W   = 32,
  parameter int  MAX_LEN = 256,
  localparam int CNT_W   = $clog2(MAX_LEN + 1),
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   cfg_signed_i,
  input  logic [CNT_W-1:0]       cfg_acc_len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NUM_CH*IN_W-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ACC_W-1:0]       out_data_o,
  output logic [CH_W-1:0]        out_ch_o,
  output logic                   out_last_o,
  output logic                   busy_o
`ifdef ACCUM_BUF_SAT_EN
  ,output logic [NUM_CH-1:0]     sat_flag_o
`endif
);

  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic             ONE_CH  = (NUM_CH == 1);

  accum_buf_state_e state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CH_W-1:0]  ptr_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic             busy_reg;

  logic [CNT_W-1:0] cfg_len;
  logic [CNT_W-1:0] count_inc;
  logic             beat_hs;
  logic             drain_hs;
  logic             drain_done;
  logic             lane_clear;
  logic             lane_add;
  logic [ACC_W-1:0] lane_acc [NUM_CH];

  assign beat_hs    = in_valid_i & in_ready_reg;
  assign drain_hs   = out_valid_reg & out_ready_i;
  assign drain_done = drain_hs & out_last_reg;
  assign lane_clear = clear_i | drain_done;
  assign lane_add   = beat_hs & ~clear_i;
  assign count_inc  = count_reg + CNT_W'(1);

  // Group length as latched on the first beat: 0 means 1, capped at MAX_LEN.
  always_comb begin
    cfg_len = cfg_acc_len_i;
    if (cfg_acc_len_i == '0) begin
      cfg_len = CNT_W'(1);
    end else if (cfg_acc_len_i > CNT_W'(MAX_LEN)) begin
      cfg_len = CNT_W'(MAX_LEN);
    end
  end

  // Group FSM with beat counter, drain pointer and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      len_reg       <= '0;
      ptr_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (clear_i) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      len_reg       <= '0;
      ptr_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (beat_hs) begin
            len_reg   <= cfg_len;
            count_reg <= CNT_W'(1);
            busy_reg  <= 1'b1;
            if (cfg_len == CNT_W'(1)) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              out_last_reg  <= ONE_CH;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat_hs) begin
            count_reg <= count_inc;
            if (count_inc == len_reg) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              out_last_reg  <= ONE_CH;
            end
          end
        end
        DRAIN: begin
          if (drain_hs) begin
            if (out_last_reg) begin
              state_reg     <= IDLE;
              count_reg     <= '0;
              len_reg       <= '0;
              ptr_reg       <= '0;
              in_ready_reg  <= 1'b1;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              busy_reg      <= 1'b0;
            end else begin
              ptr_reg      <= ptr_reg + CH_W'(1);
              out_last_reg <= ((ptr_reg + CH_W'(1)) == LAST_CH);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // One accumulator per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    accum_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear     (lane_clear),
      .add_en    (lane_add),
      .is_signed (cfg_signed_i),
      .lane_data (in_data_i[gi*IN_W +: IN_W]),
      .acc       (lane_acc[gi])
`ifdef ACCUM_BUF_SAT_EN
      ,.sat_flag (sat_flag_o[gi])
`endif
    );
  end

  // Drain mux; data and channel read as zero while no result is offered.
  always_comb begin
    out_data_o = '0;
    out_ch_o   = '0;
    if (out_valid_reg) begin
      out_data_o = lane_acc[ptr_reg];
      out_ch_o   = ptr_reg;
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign out_last_o  = out_last_reg;
  assign busy_o      = busy_reg;

endmodule
